// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR tap sequencer feeding an external MAC ALU
module fir_mac_sequencer #(
  parameter int NTAPS = 16,
  parameter int DW = 16,
  parameter int YW = 39,
  localparam int AW = $clog2(NTAPS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          coef_we_i,
  input  logic [AW-1:0] coef_addr_i,
  input  logic [DW-1:0] coef_data_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic [DW-1:0] alu_x_o,
  output logic [DW-1:0] alu_b_o,
  output logic          alu_r_o,
  input  logic [YW-1:0] alu_y_i,
  output logic          out_valid_o,
  output logic [YW-1:0] out_data_o,
  input  logic          out_ready_i,
  output logic          busy_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, OUT} state_t;
  state_t        state_q;
  logic [DW-1:0] delay_q [NTAPS];
  logic [DW-1:0] coef_q [NTAPS];
  logic [AW-1:0] wr_ptr_q, newest_q, k_q, k_d, rd_d;
  logic [DW-1:0] x_q, b_q;
  logic          out_valid_q;
  logic [YW-1:0] out_data_q;
  assign in_ready_o  = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign alu_r_o     = !rst_ni || state_q == CLEAR;
  assign alu_x_o     = x_q;
  assign alu_b_o     = b_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  // next tap index and the delay-line slot it reads (newest sample first, wrapping)
  always_comb begin
    k_d  = (state_q == MAC) ? k_q + 1'b1 : '0;
    rd_d = newest_q - k_d;
  end
  // sequencer FSM with storage and registered ALU operands
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      k_q         <= '0;
      x_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      if (coef_we_i && state_q == IDLE) coef_q[coef_addr_i] <= coef_data_i;
      case (state_q)
        IDLE: if (in_valid_i) begin
          delay_q[wr_ptr_q] <= in_data_i;
          newest_q          <= wr_ptr_q;
          wr_ptr_q          <= wr_ptr_q + 1'b1;
          k_q               <= '0;
          state_q           <= CLEAR;
        end
        CLEAR: begin
          k_q     <= '0;
          x_q     <= delay_q[rd_d];
          b_q     <= coef_q[k_d];
          state_q <= MAC;
        end
        MAC: if (k_q == AW'(NTAPS - 1)) begin
          x_q     <= '0;
          b_q     <= '0;
          state_q <= DRAIN;
        end else begin
          k_q <= k_d;
          x_q <= delay_q[rd_d];
          b_q <= coef_q[k_d];
        end
        DRAIN: begin
          out_data_q  <= alu_y_i;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
